alu_arbiter: RTL
================

# alu_arbiter

Sequencer and round-robin arbiter that shares the single combinational ALU between `NREQ` requesters (e.g. sensor-rule engine, user-command decoder). It accepts one operation at a time via a valid/ready handshake, registers the operands, and drives the ALU for exactly one enabled cycle. It then captures `alu_out`/`alu_one` and returns them to the winning requester over a per-requester valid/ready response channel. It sits between the requesters and the ALU; no other block drives the ALU inputs.

## Interface
- `NREQ`, 2: number of requesters, legal 2..4
- `WORD_SIZE`, 32: operand/result width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  one-hot accept strobe
- `req_mode`  in  2*NREQ  per requester: 0 = USER, 1 = JUMP, 2/3 illegal
- `req_opcode`  in  4*NREQ  per requester: NOP/ADD/SUB/XOR/XNOR/SGT
- `req_data_1`, `req_data_2`  in  WORD_SIZE*NREQ  operands
- `req_zero`  in  NREQ  per-request `alu_zero` override
- `rsp_valid`  out  NREQ  one-hot response valid
- `rsp_ready`  in  NREQ  response accepted
- `rsp_result`  out  WORD_SIZE  captured result
- `rsp_one`  out  1  captured JUMP flag
- `rsp_err`  out  1  illegal mode
- `alu_enable`, `alu_zero`  out  1  ALU controls
- `alu_mode`  out  2  ALU mode
- `alu_opcode`  out  4  ALU opcode
- `alu_data_1`, `alu_data_2`  out  WORD_SIZE  ALU operands
- `alu_out`  in  WORD_SIZE  ALU result
- `alu_one`  in  1  ALU JUMP flag

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any `req_valid`, grant winner `g` by round robin starting at `ptr`. Assert `req_ready[g]` combinationally this cycle and latch mode/opcode/operands/zero and `g`. Next state is ISSUE. With no request, stay in IDLE.
- ISSUE (1 cycle): drive the ALU from the latched registers with `alu_enable=1`. At the clock edge, capture the result into `rsp_result`/`rsp_one`. Next state is RESP.
  - USER mode: `rsp_result=alu_out`, `rsp_one=0`.
  - JUMP mode: `rsp_result=0`, `rsp_one=alu_one`. A latched zero of 1 forces `rsp_one=0`.
  - Illegal mode (2/3): `alu_enable` stays 0, `rsp_result=0`, `rsp_one=0`, `rsp_err=1`.
- RESP: hold `rsp_valid[g]=1` with stable data until `rsp_ready[g]`. On acceptance, set `ptr=(g+1) mod NREQ` and return to IDLE.
- `rsp_ready` on non-granted bits is ignored.
- Requester rule: hold `req_valid` and its payload stable until `req_ready`. Dropping `req_valid` early is legal; the request is then never granted.
- Outside ISSUE: `alu_enable=0`; `alu_mode`, `alu_opcode`, data and `alu_zero` are all 0. This gives a deterministic NOP to the ALU.
- SUB semantics belong to the ALU (`data_2 - data_1`); the arbiter passes operands unmodified, with no width change.

## Timing
- Reset (`rst_n=0`, async) sets: state IDLE, `ptr=0`, `req_ready=0`, `rsp_valid=0`, `rsp_result=0`, `rsp_one=0`, `rsp_err=0`, `alu_enable=0`, and all ALU outputs 0.
- Reset mid-operation drops the in-flight operation; no response is ever produced for it.
- Latency: accept at cycle T, ALU enabled at T+1, `rsp_valid` rises at T+2.
- Throughput: at best 1 operation per 3 cycles. IDLE is always visited between operations.
- Requests arriving in ISSUE/RESP wait; `req_ready` stays 0 outside IDLE.
- Simultaneous requests: the lowest index at or after `ptr` (mod NREQ) wins. `ptr` advances only on response acceptance.
- Back-pressure: `rsp_ready` held low keeps the FSM in RESP indefinitely. Outputs stay stable and no new grant is issued.

## Structure
- Shared package `alu_pkg`:
  - opcode constants NOP..CMP
  - mode constants USER/JUMP
  - `WORD_SIZE`, `OPCODE_SIZE`, `MODE_SIZE`
  - FSM state enum
- ALU and requester-side blocks import `alu_pkg`.
- Sub-module `rr_arbiter`: combinational NREQ-wide round-robin picker. Inputs are request vector and `ptr`; outputs are one-hot grant and index. The FSM, operand registers and pointer update stay in `alu_arbiter`.

## Test plan
- Single USER ADD: requester 0 sends 5 and 7. Expect `req_ready[0]` the same cycle, `alu_enable` high one cycle later, and `rsp_valid[0]` at T+2 with `rsp_result=12`, `rsp_one=0`.
- Simultaneous contention with NREQ=2: both request continuously, 4 ops each. Grants alternate 0,1,0,1…, and each response carries the correct SUB result (data_1=3, data_2=10 → 7).
- JUMP compare: equal operands 0xA5 give `rsp_one=1`. Same operands with `req_zero=1` give `rsp_one=0`. Unequal operands give 0. `rsp_result=0` in all three cases.
- Back-pressure: hold `rsp_ready` low for 10 cycles. `rsp_valid` and the data stay stable, `req_ready[1]` stays 0 despite a pending request, and the grant to 1 occurs after acceptance.
- Illegal mode 3: `alu_enable` never rises, response has `rsp_err=1`, `rsp_result=0`.
- Async reset asserted during ISSUE: all outputs return to 0 immediately with no response. After release, a new request from requester 1 is served with `ptr=0` arbitration.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester-side blocks: widths, opcodes,
// modes and the arbiter FSM state encoding.
package alu_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int OPCODE_SIZE = 4;
    localparam int MODE_SIZE   = 2;

    localparam logic [OPCODE_SIZE-1:0] OP_NOP  = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_XOR  = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] OP_XNOR = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] OP_SGT  = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] OP_CMP  = 4'd6;

    localparam logic [MODE_SIZE-1:0] MODE_USER = 2'd0;
    localparam logic [MODE_SIZE-1:0] MODE_JUMP = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } arb_state_t;

    function automatic logic mode_legal(input logic [MODE_SIZE-1:0] mode);
        return (mode == MODE_USER) || (mode == MODE_JUMP);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i
// (wrapping modulo NREQ) wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin accept,
// one enabled ALU cycle, then a held per-requester response.
//
// state    | meaning
// ST_IDLE  | waiting for a request; grant is combinational, payload latched
// ST_ISSUE | ALU driven from latched operands, result captured at the edge
// ST_RESP  | rsp_valid held to the winner until its rsp_ready
module alu_arbiter import alu_pkg::*; #(
    parameter int NREQ      = 2,
    parameter int WORD_SIZE = alu_pkg::WORD_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [MODE_SIZE*NREQ-1:0]     req_mode,
    input  logic [OPCODE_SIZE*NREQ-1:0]   req_opcode,
    input  logic [WORD_SIZE*NREQ-1:0]     req_data_1,
    input  logic [WORD_SIZE*NREQ-1:0]     req_data_2,
    input  logic [NREQ-1:0]               req_zero,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [WORD_SIZE-1:0]          rsp_result,
    output logic                          rsp_one,
    output logic                          rsp_err,
    output logic                          alu_enable,
    output logic                          alu_zero,
    output logic [MODE_SIZE-1:0]          alu_mode,
    output logic [OPCODE_SIZE-1:0]        alu_opcode,
    output logic [WORD_SIZE-1:0]          alu_data_1,
    output logic [WORD_SIZE-1:0]          alu_data_2,
    input  logic [WORD_SIZE-1:0]          alu_out,
    input  logic                          alu_one
);

    localparam int IW = $clog2(NREQ);

    arb_state_t             state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          gnt_q, gnt_d;
    logic [MODE_SIZE-1:0]   mode_q, mode_d;
    logic [OPCODE_SIZE-1:0] op_q, op_d;
    logic [WORD_SIZE-1:0]   d1_q, d1_d;
    logic [WORD_SIZE-1:0]   d2_q, d2_d;
    logic                   zero_q, zero_d;
    logic [WORD_SIZE-1:0]   result_q, result_d;
    logic                   one_q, one_d;
    logic                   err_q, err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign rsp_result = result_q;
    assign rsp_one    = one_q;
    assign rsp_err    = err_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        mode_d     = mode_q;
        op_d       = op_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        zero_d     = zero_q;
        result_d   = result_q;
        one_d      = one_q;
        err_d      = err_q;
        req_ready  = '0;
        rsp_valid  = '0;
        alu_enable = 1'b0;
        alu_zero   = 1'b0;
        alu_mode   = '0;
        alu_opcode = '0;
        alu_data_1 = '0;
        alu_data_2 = '0;

        case (state_q)
            ST_IDLE: begin
                // rst_n gate keeps the accept strobe quiet while reset is held
                if (pick_any && rst_n) begin
                    req_ready = pick_gnt;
                    gnt_d     = pick_idx;
                    mode_d    = req_mode[pick_idx*MODE_SIZE +: MODE_SIZE];
                    op_d      = req_opcode[pick_idx*OPCODE_SIZE +: OPCODE_SIZE];
                    d1_d      = req_data_1[pick_idx*WORD_SIZE +: WORD_SIZE];
                    d2_d      = req_data_2[pick_idx*WORD_SIZE +: WORD_SIZE];
                    zero_d    = req_zero[pick_idx];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // illegal modes leave the ALU on its all-zero NOP
                if (mode_legal(mode_q)) begin
                    alu_enable = 1'b1;
                    alu_zero   = zero_q;
                    alu_mode   = mode_q;
                    alu_opcode = op_q;
                    alu_data_1 = d1_q;
                    alu_data_2 = d2_q;
                end
                result_d = (mode_q == MODE_USER) ? alu_out : '0;
                one_d    = (mode_q == MODE_JUMP) && !zero_q && alu_one;
                err_d    = !mode_legal(mode_q);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            mode_q   <= '0;
            op_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            zero_q   <= 1'b0;
            result_q <= '0;
            one_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            mode_q   <= mode_d;
            op_q     <= op_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            one_q    <= one_d;
            err_q    <= err_d;
        end
    end

endmodule
